// File: rtl/div_iter_unit_pkg.sv
// Shared types and the restoring-division step for the EX-stage iterative divider.
package div_pkg;
    localparam int          DIV_WIDTH     = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        DIV_WU = 2'b00,
        MOD_WU = 2'b01,
        DIV_W  = 2'b10,
        MOD_W  = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] rem;
        logic                 q;
    } div_step_t;

    // Compare is done on 33 bits so unsigned divisors with bit 31 set stay exact.
    function automatic div_step_t div_step(input logic [DIV_WIDTH-1:0] rem,
                                           input logic                 dvd_msb,
                                           input logic [DIV_WIDTH-1:0] dvs);
        logic [DIV_WIDTH:0] sh;
        div_step_t          r;
        sh = {rem, dvd_msb};
        if (sh >= {1'b0, dvs}) begin
            r.rem = DIV_WIDTH'(sh - {1'b0, dvs});
            r.q   = 1'b1;
        end else begin
            r.rem = sh[DIV_WIDTH-1:0];
            r.q   = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [DIV_WIDTH-1:0] div_neg_if(input logic neg,
                                                        input logic [DIV_WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction
endpackage

// File: rtl/div_iter_unit_if.sv
// Slot-A EX-stage divide request/result bundle between the pipeline and the divider.
interface div_iter_unit_if #(parameter int WIDTH = 32) ();
    logic             EX_div_en;
    logic [1:0]       EX_div_op;
    logic [WIDTH-1:0] EX_src_a;
    logic [WIDTH-1:0] EX_src_b;
    logic             stall_dcache;
    logic             flush;
    logic             stall_div;
    logic [WIDTH-1:0] EX_div_result;

    modport master (
        output EX_div_en, EX_div_op, EX_src_a, EX_src_b, stall_dcache, flush,
        input  stall_div, EX_div_result
    );

    modport slave (
        input  EX_div_en, EX_div_op, EX_src_a, EX_src_b, stall_dcache, flush,
        output stall_div, EX_div_result
    );
endinterface

// File: rtl/div_iter_unit.sv
// Restoring radix-2 divider: one quotient bit per cycle, holds the pipeline via stall_div.
module div_iter_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic            clk,
    input  logic            rstn,
    div_iter_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(ITER);

    div_state_t       r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd, r_dvs, r_rem, r_quo, r_result;
    logic             r_sign_q, r_sign_r;
    div_op_t          r_op;

    div_op_t          w_op;
    logic             w_sgn_in, w_sa, w_sb, w_start, w_dvs_zero, w_last;
    logic             w_is_mod, w_is_sgn;
    div_step_t        w_step;
    logic [WIDTH-1:0] w_quo_fin, w_res_fin;

    assign w_op       = div_op_t'(bus.EX_div_op);
    assign w_sgn_in   = (w_op == DIV_W) || (w_op == MOD_W);
    assign w_sa       = w_sgn_in & bus.EX_src_a[WIDTH-1];
    assign w_sb       = w_sgn_in & bus.EX_src_b[WIDTH-1];
    assign w_start    = (r_state == IDLE) && bus.EX_div_en && !bus.flush;
    assign w_dvs_zero = (bus.EX_src_b == '0);
    assign w_last     = (r_cnt == CNT_W'(ITER - 1));

    assign w_is_mod   = (r_op == MOD_WU) || (r_op == MOD_W);
    assign w_is_sgn   = (r_op == DIV_W)  || (r_op == MOD_W);
    assign w_step     = div_step(r_rem, r_dvd[WIDTH-1], r_dvs);
    assign w_quo_fin  = {r_quo[WIDTH-2:0], w_step.q};
    // Sign fix-up folded into the final iteration so DONE sees the finished value.
    assign w_res_fin  = w_is_mod ? div_neg_if(w_is_sgn & r_sign_r, w_step.rem)
                                 : div_neg_if(w_is_sgn & r_sign_q, w_quo_fin);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (bus.EX_div_en) w_next = w_dvs_zero ? DONE : CALC;
                CALC:    if (w_last) w_next = DONE;
                DONE:    if (!bus.stall_dcache) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.stall_div = 1'b0;
        if (!bus.flush)
            bus.stall_div = (r_state == CALC) || ((r_state == IDLE) && bus.EX_div_en);
    end

    assign bus.EX_div_result = r_result;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_result <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_op     <= DIV_WU;
        end else if (w_start) begin
            if (w_dvs_zero) begin
                r_result <= (w_op == MOD_WU || w_op == MOD_W) ? bus.EX_src_a : DIV_BY_ZERO_Q;
            end else begin
                r_dvd    <= div_neg_if(w_sa, bus.EX_src_a);
                r_dvs    <= div_neg_if(w_sb, bus.EX_src_b);
                r_sign_q <= w_sa ^ w_sb;
                r_sign_r <= w_sa;
                r_op     <= w_op;
                r_rem    <= '0;
                r_quo    <= '0;
                r_cnt    <= '0;
            end
        end else if (r_state == CALC && !bus.flush) begin
            r_rem <= w_step.rem;
            r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
            r_quo <= w_quo_fin;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_result <= w_res_fin;
        end
    end
endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed vectors, abort sequences, random vs. arithmetic model.
module tb_div_iter_unit;
    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    div_iter_unit_if #(.WIDTH(32)) bus ();

    div_iter_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          st;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: plain 64-bit arithmetic, SV truncates toward zero.
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
        if (op[1]) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return op[0] ? r[31:0] : q[31:0];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            6:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issues one instruction as the pipeline would; holds DONE for 'hold' extra cycles.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output logic [31:0] res, output int stalls);
        bit done = 1'b0;
        @(negedge clk);
        bus.EX_div_en = 1'b1;
        bus.EX_div_op = op;
        bus.EX_src_a  = a;
        bus.EX_src_b  = b;
        stalls = 0;
        for (int g = 0; g < 100; g++) begin
            #1;
            if (!bus.stall_div) begin
                done = 1'b1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: stall_div stuck high, expected release within 100 cycles");
        end
        res = bus.EX_div_result;
        if (hold > 0) begin
            bus.stall_dcache = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                #1;
                chk("hold_stall", 32'(bus.stall_div), 32'd0);
                chk("hold_result", bus.EX_div_result, res);
            end
            bus.stall_dcache = 1'b0;
        end
        bus.EX_div_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int          st;
        logic [1:0]  op;
        logic [31:0] a, b;

        vecs[0]  = '{2'b10, 32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        vecs[3]  = '{2'b11, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
        vecs[5]  = '{2'b00, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  33};
        vecs[6]  = '{2'b01, 32'hFFFF_FFFF,  32'd2,          32'd1,          33};
        vecs[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
        vecs[8]  = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
        vecs[9]  = '{2'b10, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[10] = '{2'b01, 32'hDEAD_BEEF,  32'd0,          32'hDEAD_BEEF,  1};
        vecs[11] = '{2'b00, 32'd50,         32'd5,          32'd10,         33};
        vecs[12] = '{2'b00, 32'd9,          32'd3,          32'd3,          33};

        rstn             = 1'b0;
        bus.EX_div_en    = 1'b0;
        bus.EX_div_op    = 2'b00;
        bus.EX_src_a     = '0;
        bus.EX_src_b     = '0;
        bus.stall_dcache = 1'b0;
        bus.flush        = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall", 32'(bus.stall_div), 32'd0);
        chk("reset_result", bus.EX_div_result, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed table, issued back-to-back; vector 10 also holds DONE for 3 cycles.
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i == 10) ? 3 : 0, res, st);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].st));
        end

        // Flush in CALC cycle 10: no stall that cycle, idle afterwards.
        @(negedge clk);
        bus.EX_div_en = 1'b1;
        bus.EX_div_op = 2'b10;
        bus.EX_src_a  = 32'd100;
        bus.EX_src_b  = 32'd7;
        repeat (11) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("flush_stall", 32'(bus.stall_div), 32'd0);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.EX_div_en = 1'b0;
        #1;
        chk("flush_idle", 32'(bus.stall_div), 32'd0);
        run_op(2'b10, 32'd20, 32'd4, 0, res, st);
        chk("post_flush_result", res, 32'd5);
        chk("post_flush_stall", 32'(st), 32'd33);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        bus.EX_div_en = 1'b1;
        bus.EX_div_op = 2'b00;
        bus.EX_src_a  = 32'd1000;
        bus.EX_src_b  = 32'd3;
        repeat (6) @(negedge clk);
        #1;
        chk("calc_stall", 32'(bus.stall_div), 32'd1);
        bus.EX_div_en = 1'b0;
        rstn = 1'b0;
        #1;
        chk("midreset_stall", 32'(bus.stall_div), 32'd0);
        chk("midreset_result", bus.EX_div_result, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        chk("postreset_idle", 32'(bus.stall_div), 32'd0);
        run_op(2'b00, 32'd9, 32'd3, 0, res, st);
        chk("postreset_result", res, 32'd3);
        chk("postreset_stall", 32'(st), 32'd33);

        // Random regression against the arithmetic model.
        for (int n = 0; n < 1200; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            run_op(op, a, b, ($urandom_range(0, 7) == 0) ? 2 : 0, res, st);
            chk("rand_result", res, ref_res(op, a, b));
            chk("rand_stall", 32'(st), (b == 32'd0) ? 32'd1 : 32'd33);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
